// File: rtl/sort_frame_loader.sv
// Serial-to-parallel feeder for the odd-even transposition sort array: gathers
// up to N keys, strobes them into the array, waits out the sort and flags done.
module sort_frame_loader #(
    parameter int             N           = 8,
    parameter int             W           = 8,
    parameter int             SORT_CYCLES = 4,
    parameter logic [W-1:0]   PAD         = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic                 in_last,
    input  logic                 flush,
    output logic [N*W-1:0]       frame_data,
    output logic                 frame_load,
    output logic                 frame_done,
    output logic [$clog2(N):0]   frame_len,
    output logic                 busy
);
    localparam int CW  = $clog2(N);
    localparam int LW  = CW + 1;
    localparam int SCW = $clog2(SORT_CYCLES + 1);

    typedef enum logic [1:0] {COLLECT, LOAD, SORT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [N-1:0][W-1:0]    lanes_q, lanes_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [LW-1:0]          len_q, len_d;
    logic [SCW-1:0]         sort_cnt_q, sort_cnt_d;
    logic                   hs, close, sort_last;

    assign hs        = in_valid && in_ready;
    // The N-th key closes the frame even without in_last.
    assign close     = hs && (in_last || cnt_q == CW'(N - 1));
    assign sort_last = sort_cnt_q == SCW'(SORT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (close)     state_d = LOAD;
            LOAD:                   state_d = SORT;
            SORT:    if (sort_last) state_d = DONE;
            DONE:                   state_d = COLLECT;
            default:                state_d = COLLECT;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == COLLECT) && !flush;
        busy       = state_q != COLLECT;
        frame_load = state_q == LOAD;
        frame_done = state_q == DONE;
    end

    always_comb begin
        lanes_d    = lanes_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sort_cnt_d = sort_cnt_q;
        case (state_q)
            COLLECT: begin
                if (flush) begin
                    cnt_d   = '0;
                    lanes_d = {N{PAD}};
                end else if (hs) begin
                    lanes_d[cnt_q] = in_data;
                    cnt_d          = cnt_q + CW'(1);
                    if (close) begin
                        len_d = {1'b0, cnt_q} + LW'(1);
                        cnt_d = '0;
                    end
                end
            end
            SORT:    sort_cnt_d = sort_last ? '0 : sort_cnt_q + SCW'(1);
            // Unused lanes of the next frame must read PAD, so clear on exit.
            DONE:    lanes_d = {N{PAD}};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q    <= {N{PAD}};
            cnt_q      <= '0;
            len_q      <= '0;
            sort_cnt_q <= '0;
        end else begin
            lanes_q    <= lanes_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sort_cnt_q <= sort_cnt_d;
        end
    end

    assign frame_data = lanes_q;
    assign frame_len  = len_q;
endmodule

// File: tb/tb_sort_frame_loader.sv
// Bench for sort_frame_loader: directed test-plan steps plus random traffic,
// compared every cycle against a frame/timeline reference model.
module tb_sort_frame_loader;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SC = 4;
    localparam int NW = N * W;
    localparam int LW = $clog2(N) + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, in_last, flush;
    logic [W-1:0]   in_data;
    logic [NW-1:0]  frame_data;
    logic           frame_load, frame_done, busy;
    logic [LW-1:0]  frame_len;

    always #5 clk = ~clk;

    sort_frame_loader #(.N(N), .W(W), .SORT_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .flush(flush),
        .frame_data(frame_data), .frame_load(frame_load), .frame_done(frame_done),
        .frame_len(frame_len), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: collected keys, last closed length, and cycles elapsed
    // since the frame closed (-1 while collecting).
    logic [W-1:0] m_lanes [N];
    int           m_keys, m_len, m_since;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_lanes[i] = '1;
        m_keys = 0; m_len = 0; m_since = -1;
    endtask

    function automatic logic [NW-1:0] m_pack();
        logic [NW-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = m_lanes[i];
        return p;
    endfunction

    task automatic check_outputs();
        chk("in_ready",   64'(in_ready),   64'(m_since < 0 && !flush));
        chk("busy",       64'(busy),       64'(m_since >= 0));
        chk("frame_load", 64'(frame_load), 64'(m_since == 0));
        chk("frame_done", 64'(frame_done), 64'(m_since == SC + 1));
        chk("frame_data", 64'(frame_data), 64'(m_pack()));
        chk("frame_len",  64'(frame_len),  64'(m_len));
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic l, input logic f);
        if (m_since < 0) begin
            if (f) begin
                for (int i = 0; i < N; i++) m_lanes[i] = '1;
                m_keys = 0;
            end else if (v) begin
                m_lanes[m_keys] = d;
                m_keys++;
                if (l || m_keys == N) begin
                    m_len = m_keys; m_keys = 0; m_since = 0;
                end
            end
        end else begin
            m_since++;
            if (m_since > SC + 1) begin
                m_since = -1;
                for (int i = 0; i < N; i++) m_lanes[i] = '1;
            end
        end
    endtask

    // One clock: drive, check before the edge, advance the model across it.
    task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic f);
        in_valid = v; in_data = d; in_last = l; flush = f;
        @(negedge clk);
        check_outputs();
        model_edge(v, d, l, f);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_t1();
        logic [W-1:0] k [8];
        k = '{8'h50, 8'h10, 8'hF0, 8'h30, 8'h70, 8'h20, 8'h60, 8'h40};
        for (int i = 0; i < 8; i++) step(1'b1, k[i], i == 7, 1'b0);
    endtask

    initial begin
        logic [W-1:0] key, k6 [10];
        logic         v, l, f, hs, seen8;
        int           idx, guard;

        reset = 1'b1; in_valid = 0; in_data = 0; in_last = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_len",  64'(frame_len),  64'd0);
        chk("rst_data", 64'(frame_data), {64{1'b1}});
        chk("rst_busy", 64'(busy),       64'd0);
        check_outputs();
        reset = 1'b0;

        // Test 1: full frame with in_last on key 8
        send_t1();
        chk("t1_data", 64'(frame_data), 64'h4060207030F01050);
        chk("t1_len",  64'(frame_len),  64'd8);
        chk("t1_load", 64'(frame_load), 64'd1);
        idle(SC + 3);

        // Test 2: short frame
        step(1'b1, 8'h09, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b1, 1'b0);
        chk("t2_data", 64'(frame_data), 64'hFFFFFFFFFF070309);
        chk("t2_len",  64'(frame_len),  64'd3);
        idle(SC + 3);

        // Test 3: toggling valid, offers held through busy until accepted
        key = 8'($urandom);
        for (int c = 0; c < 60; c++) begin
            v  = (c % 2) == 0;
            l  = $urandom_range(0, 3) == 0;
            hs = v && m_since < 0;
            step(v, key, l, 1'b0);
            if (hs) key = 8'($urandom);
        end
        idle(SC + 3);

        // Test 4: flush after two keys, with a key offered alongside flush
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        chk("t4_data", 64'(frame_data), 64'hFFFFFFFFFFFF4433);
        chk("t4_len",  64'(frame_len),  64'd2);
        idle(SC + 3);

        // Test 5: async reset in the second SORT cycle
        send_t1();
        idle(2);
        #2 reset = 1'b1;
        #1;
        chk("t5_busy", 64'(busy),       64'd0);
        chk("t5_data", 64'(frame_data), {64{1'b1}});
        chk("t5_len",  64'(frame_len),  64'd0);
        chk("t5_done", 64'(frame_done), 64'd0);
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        idle(SC + 4);
        send_t1();
        chk("t5b_data", 64'(frame_data), 64'h4060207030F01050);
        chk("t5b_len",  64'(frame_len),  64'd8);
        idle(SC + 3);

        // Test 6: 10 keys without last until key 10
        for (int i = 0; i < 10; i++) k6[i] = 8'($urandom_range(0, 254));
        idx = 0; guard = 0; seen8 = 1'b0;
        while (idx < 10 && guard < 100) begin
            hs = m_since < 0;
            step(1'b1, k6[idx], idx == 9, 1'b0);
            if (hs) idx++;
            if (m_since == 0 && !seen8) begin
                seen8 = 1'b1;
                chk("t6_len8", 64'(frame_len), 64'd8);
            end
            guard++;
        end
        chk("t6_guard", 64'(idx), 64'd10);
        chk("t6_len2",  64'(frame_len), 64'd2);
        chk("t6_data",  64'(frame_data), {48'hFFFFFFFFFFFF, k6[9], k6[8]});
        idle(SC + 3);

        // Random traffic including flushes
        for (int c = 0; c < 400; c++) begin
            v = $urandom_range(0, 2) != 0;
            l = $urandom_range(0, 4) == 0;
            f = $urandom_range(0, 15) == 0;
            step(v, 8'($urandom), l, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
